// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence monitor: FSM encodings,
// error-flag bit positions and the default sequence width.
package lfsr_pkg;

    localparam int LFSR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ERR_W       = 3;
    localparam int ERR_EARLY   = 0;
    localparam int ERR_MISSING = 1;
    localparam int ERR_STUCK   = 2;

endpackage

// File: rtl/lfsr_monitor_sat_counter.sv
// 8-bit event counter that adds 0, 1 or 2 per cycle and sticks at 255.
module sat_counter
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [1:0] inc,
    output logic [7:0] value
);

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else begin
            value <= sat_add(value, inc);
        end
    end

endmodule

// File: rtl/lfsr_monitor.sv
// Checks that a full-period (2^WIDTH, zero included) LFSR stream repeats
// exactly once per period, flagging early zeros, missing zeros and stuck values.
module lfsr_monitor
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err,
    output logic [WIDTH:0]   period,
    output logic [7:0]       err_count
);

    localparam logic [WIDTH:0] N   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [WIDTH:0]     count, count_nxt, count_inc, period_nxt;
    logic [WIDTH-1:0]   prev, prev_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic [1:0]         inc;
    logic               clr;
    logic               is_zero, is_stuck, closing, seq_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        prev_nxt   = prev;
        err_nxt    = err;
        period_nxt = period;
        inc        = 2'd0;
        clr        = 1'b0;
        count_inc  = count + ONE;
        is_zero    = (in_data == '0);
        is_stuck   = (in_data == prev);
        closing    = (count_inc == N);
        // Closing sample must be zero; any other sample must not be.
        seq_evt    = closing ? !is_zero : is_zero;

        if (start) begin
            state_nxt  = ST_ALIGN;
            count_nxt  = '0;
            prev_nxt   = '0;
            err_nxt    = '0;
            period_nxt = '0;
            clr        = 1'b1;
        end else if (in_valid) begin
            case (state)
                ST_ALIGN: begin
                    if (is_zero) begin
                        state_nxt = ST_RUN;
                        count_nxt = '0;
                        prev_nxt  = '0;
                    end else begin
                        count_nxt = count_inc;
                        if (closing) begin
                            err_nxt[ERR_MISSING] = 1'b1;
                            inc                  = 2'd1;
                            state_nxt            = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    count_nxt = count_inc;
                    prev_nxt  = in_data;
                    if (closing) begin
                        period_nxt = N;
                        state_nxt  = ST_DONE;
                        if (!is_zero) err_nxt[ERR_MISSING] = 1'b1;
                    end else if (is_zero) begin
                        err_nxt[ERR_EARLY] = 1'b1;
                    end
                    if (is_stuck) err_nxt[ERR_STUCK] = 1'b1;
                    inc = {1'b0, seq_evt} + {1'b0, is_stuck};
                end
                default: ;
            endcase
        end
    end

    // Flags are derived from next-state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            prev   <= '0;
            err    <= '0;
            period <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            count  <= count_nxt;
            prev   <= prev_nxt;
            err    <= err_nxt;
            period <= period_nxt;
            busy   <= (state_nxt == ST_ALIGN) || (state_nxt == ST_RUN);
            done   <= (state_nxt == ST_DONE);
            pass   <= (state_nxt == ST_DONE) && (err_nxt == '0);
        end
    end

    sat_counter u_err_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc),
        .value (err_count)
    );

endmodule

// File: tb/tb_lfsr_monitor.sv
// Directed bench for lfsr_monitor at WIDTH=4 using a hand-listed
// full-period (zero-inserted) 4-bit LFSR sequence.
module tb_lfsr_monitor;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err;
    logic [4:0] period;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_err = 0;

    // x^4+x^3+1 Fibonacci LFSR with the all-zero state spliced in after 1000.
    logic [3:0] seq [16] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13,
                             4'd10, 4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    logic [3:0] vec [17];

    lfsr_monitor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err       (err),
        .period    (period),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] d);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            step();
        end
    endtask

    task automatic load_clean();
        for (int i = 0; i < 16; i++) vec[i] = seq[i];
        vec[16] = 4'd0;
    endtask

    task automatic play(input string tag, input bit gaps);
        for (int i = 0; i < 17; i++) begin
            if (gaps) idle_gap();
            send(vec[i]);
            if (i == 15) check_eq({tag, ".done_before_close"}, 32'(done), 32'd0);
        end
    endtask

    task automatic check_result(input string tag, input logic e_pass, input logic [2:0] e_err,
                                input logic [4:0] e_period, input logic [7:0] e_cnt);
        check_eq({tag, ".done"},      32'(done),      32'd1);
        check_eq({tag, ".busy"},      32'(busy),      32'd0);
        check_eq({tag, ".pass"},      32'(pass),      32'(e_pass));
        check_eq({tag, ".err"},       32'(err),       32'(e_err));
        check_eq({tag, ".period"},    32'(period),    32'(e_period));
        check_eq({tag, ".err_count"}, 32'(err_count), 32'(e_cnt));
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        #12;
        check_eq("rst.busy",      32'(busy),      32'd0);
        check_eq("rst.done",      32'(done),      32'd0);
        check_eq("rst.pass",      32'(pass),      32'd0);
        check_eq("rst.err",       32'(err),       32'd0);
        check_eq("rst.period",    32'(period),    32'd0);
        check_eq("rst.err_count", 32'(err_count), 32'd0);
        rst = 1'b1;
        step();
        send(4'd0);
        check_eq("idle.valid_ignored", 32'(busy), 32'd0);

        // Clean run, with non-zero samples before the aligning zero.
        pulse_start(4'd7);
        check_eq("clean.busy_after_start", 32'(busy), 32'd1);
        for (int i = 10; i < 16; i++) send(seq[i]);
        check_eq("clean.align_busy", 32'(busy), 32'd1);
        load_clean();
        play("clean", 1'b0);
        check_result("clean", 1'b1, 3'b000, 5'd16, 8'd0);
        send(4'd0);
        send(4'd5);
        check_result("clean.hold", 1'b1, 3'b000, 5'd16, 8'd0);

        // Early zero at RUN sample 7.
        pulse_start(4'd0);
        load_clean();
        vec[7] = 4'd0;
        play("early", 1'b0);
        check_result("early", 1'b0, 3'b001, 5'd16, 8'd1);

        // Closing zero replaced by 5.
        pulse_start(4'd0);
        load_clean();
        vec[16] = 4'd5;
        play("missing", 1'b0);
        check_result("missing", 1'b0, 3'b010, 5'd16, 8'd1);

        // Never aligns: constant 3.
        pulse_start(4'd3);
        for (int i = 0; i < 15; i++) send(4'd3);
        check_eq("timeout.not_yet", 32'(done), 32'd0);
        check_eq("timeout.busy",    32'(busy), 32'd1);
        send(4'd3);
        check_result("timeout", 1'b0, 3'b010, 5'd0, 8'd1);

        // 9 repeated in RUN, with random in_valid gaps carrying garbage data.
        pulse_start(4'd0);
        load_clean();
        vec[5] = 4'd9;
        play("stuck", 1'b1);
        check_result("stuck", 1'b0, 3'b100, 5'd16, 8'd1);

        // Early zero that also repeats prev=0 counts twice.
        pulse_start(4'd0);
        load_clean();
        vec[1] = 4'd0;
        play("double", 1'b0);
        check_result("double", 1'b0, 3'b101, 5'd16, 8'd2);

        // All zeros: 15 double events plus a stuck closing zero.
        pulse_start(4'd0);
        for (int i = 0; i < 17; i++) vec[i] = 4'd0;
        play("zeros", 1'b0);
        check_result("zeros", 1'b0, 3'b101, 5'd16, 8'd31);

        // Reset in the middle of RUN, then a clean run.
        pulse_start(4'd0);
        load_clean();
        for (int i = 0; i < 9; i++) send(vec[i]);
        in_valid = 1'b1;
        in_data  = 4'd0;
        rst      = 1'b0;
        #2;
        check_eq("midrst.busy",      32'(busy),      32'd0);
        check_eq("midrst.done",      32'(done),      32'd0);
        check_eq("midrst.err_count", 32'(err_count), 32'd0);
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("midrst.idle_busy", 32'(busy), 32'd0);
        check_eq("midrst.idle_done", 32'(done), 32'd0);
        pulse_start(4'd0);
        play("midrst.rerun", 1'b0);
        check_result("midrst.rerun", 1'b1, 3'b000, 5'd16, 8'd0);

        // Restart mid-RUN; the zero on the start cycle must be ignored.
        pulse_start(4'd0);
        for (int i = 0; i < 6; i++) send(seq[i]);
        pulse_start(4'd0);
        check_eq("restart.busy", 32'(busy), 32'd1);
        for (int i = 10; i < 16; i++) send(seq[i]);
        load_clean();
        play("restart", 1'b0);
        check_result("restart", 1'b1, 3'b000, 5'd16, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
